// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor with a valid/ready stream on both sides.
// The carry chain is cut into STAGES registered segments; S/Co/V/Z leave from the last stage.
module pipelined_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
    input  logic             M,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Co,
    output logic             V,
    output logic             Z
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int PIPE = (STAGES > 1) ? STAGES - 1 : 1;
    localparam int LAST = STAGES - 1;
    localparam int MSB  = WIDTH - 1;

    function automatic logic ovf_flag(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    function automatic logic zero_flag(input logic [WIDTH-1:0] s);
        return (s == '0);
    endfunction

    logic adv;

    // Intermediate stages only; the last stage lands directly in the output registers.
    logic [WIDTH-1:0] a_p [PIPE];
    logic [WIDTH-1:0] b_p [PIPE];
    logic [WIDTH-1:0] s_p [PIPE];
    logic [PIPE-1:0]  c_p;
    logic [STAGES-1:0] vld_p;

    logic [WIDTH-1:0] a_in [STAGES];
    logic [WIDTH-1:0] b_in [STAGES];
    logic [WIDTH-1:0] s_in [STAGES];
    logic [WIDTH-1:0] s_nx [STAGES];
    logic [STAGES-1:0] c_in;
    logic [STAGES-1:0] c_nx;
    logic [STAGES-1:0] v_in;
    logic [SEG:0]      part;

    assign adv       = out_ready || !out_valid;
    assign in_ready  = adv;
    assign out_valid = vld_p[LAST];

    always_comb begin
        part    = '0;
        // Subtraction is folded into the operand: B is inverted and the borrow-in becomes ~Ci.
        a_in[0] = A;
        b_in[0] = M ? ~B : B;
        s_in[0] = '0;
        c_in[0] = M ? ~Ci : Ci;
        v_in[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_in[k] = a_p[k-1];
            b_in[k] = b_p[k-1];
            s_in[k] = s_p[k-1];
            c_in[k] = c_p[k-1];
            v_in[k] = vld_p[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            part = {1'b0, a_in[k][k*SEG +: SEG]} + {1'b0, b_in[k][k*SEG +: SEG]}
                 + {{SEG{1'b0}}, c_in[k]};
            s_nx[k] = s_in[k];
            s_nx[k][k*SEG +: SEG] = part[SEG-1:0];
            c_nx[k] = part[SEG];
        end
    end

    // ---- stage 0 .. STAGES-2: operand and partial-sum registers ----
    always_ff @(posedge clk) begin
        if (adv) begin
            for (int k = 0; k < STAGES - 1; k++) begin
                a_p[k] <= a_in[k];
                b_p[k] <= b_in[k];
                s_p[k] <= s_nx[k];
                c_p[k] <= c_nx[k];
            end
        end
    end

    // ---- stage valid bits and output stage STAGES-1 ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
            S     <= '0;
            Co    <= 1'b0;
            V     <= 1'b0;
            Z     <= 1'b0;
        end else if (adv) begin
            vld_p <= v_in;
            S     <= s_nx[LAST];
            Co    <= c_nx[LAST];
            V     <= ovf_flag(a_in[LAST][MSB], b_in[LAST][MSB], s_nx[LAST][MSB]);
            Z     <= zero_flag(s_nx[LAST]);
        end
    end

endmodule
